// File: rtl/ramb_multirank_if.sv
// ============================================================================
// ramb_multirank_if : request/response bus for ramb_multirank (RAMB_PARITY_EN
// adds the inj_err/rsp_err parity sideband).          Rev 1.0
// ============================================================================
`default_nettype none

interface ramb_multirank_if #(
  parameter int NUM_RANKS      = 2,
  parameter int WORDADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = 8
);
  localparam int RANK_BITS  = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int ADDR_WIDTH = RANK_BITS + WORDADDR_WIDTH;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [RANK_BITS-1:0]  rsp_rank;
  logic                  busy;
`ifdef RAMB_PARITY_EN
  logic                  inj_err;
  logic [BE_WIDTH-1:0]   rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, inj_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rank, busy, rsp_err
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, inj_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_rank, busy, rsp_err
  );
`else
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rank, busy
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_rank, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/ramb_multirank.sv
// ============================================================================
// ramb_multirank : multi-rank RAM with byte enables, read-latency pipeline and
// rank-switch turnaround. Optional parity via RAMB_PARITY_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module ramb_multirank #(
  parameter int NUM_RANKS      = 2,
  parameter int WORDADDR_WIDTH = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int TURNAROUND     = 1
) (
  input wire               clk,
  input wire               rst,
  ramb_multirank_if.slave  mem_bus
);
  localparam int RANK_BITS  = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
  localparam int ADDR_WIDTH = RANK_BITS + WORDADDR_WIDTH;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int LAST       = READ_LATENCY - 1;
  localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [RANK_BITS-1:0]  last_rank_q, last_rank_d;
  logic [2:0]            turn_cnt_q, turn_cnt_d;
  logic [READ_LATENCY-1:0] pv_q;
  logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY];
  logic [RANK_BITS-1:0]  pr_q [READ_LATENCY];

  logic [RANK_BITS-1:0]  req_rank;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;

  assign req_rank  = mem_bus.req_addr[ADDR_WIDTH-1 -: RANK_BITS];
  assign rd_word   = mem_q[mem_bus.req_addr];
  assign mem_bus.req_ready = !(mem_bus.req_valid && (req_rank != last_rank_q) &&
                               (turn_cnt_q != 3'd0));
  assign accept    = mem_bus.req_valid & mem_bus.req_ready;
  assign rd_accept = accept & ~mem_bus.req_wr;
  assign wr_accept = accept &  mem_bus.req_wr;

  // Every accept, including an all-lanes-off write, restarts the turnaround window.
  always_comb begin
    last_rank_d = last_rank_q;
    turn_cnt_d  = turn_cnt_q;
    if (accept) begin
      last_rank_d = req_rank;
      turn_cnt_d  = TURN_LOAD;
    end else if (turn_cnt_q != 3'd0) begin
      turn_cnt_d  = turn_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rank_q <= '0;
      turn_cnt_q  <= '0;
    end else begin
      last_rank_q <= last_rank_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (mem_bus.req_be[i]) mem_q[mem_bus.req_addr][8*i +: 8] <= mem_bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Data/rank stages load only behind a valid bit, so the output holds the last read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pd_q[i] <= '0;
        pr_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_accept;
      if (rd_accept) begin
        pd_q[0] <= rd_word;
        pr_q[0] <= req_rank;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
          pr_q[i] <= pr_q[i-1];
        end
      end
    end
  end

  assign mem_bus.rsp_valid = pv_q[LAST];
  assign mem_bus.rsp_rdata = pd_q[LAST];
  assign mem_bus.rsp_rank  = pr_q[LAST];
  assign mem_bus.busy      = |pv_q;

`ifdef RAMB_PARITY_EN
  logic [BE_WIDTH-1:0] par_q [DEPTH];
  logic [BE_WIDTH-1:0] pe_q  [READ_LATENCY];
  logic [BE_WIDTH-1:0] rd_par;
  logic [BE_WIDTH-1:0] rd_err;

  assign rd_par = par_q[mem_bus.req_addr];

  always_comb begin
    rd_err = '0;
    for (int i = 0; i < BE_WIDTH; i++) rd_err[i] = (^rd_word[8*i +: 8]) ^ rd_par[i];
  end

  // Even parity; inj_err flips the stored bit so the next read flags the lane.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (mem_bus.req_be[i]) par_q[mem_bus.req_addr][i] <= (^mem_bus.req_wdata[8*i +: 8]) ^ mem_bus.inj_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pe_q[i] <= '0;
    end else begin
      if (rd_accept) pe_q[0] <= rd_err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        if (pv_q[i-1]) pe_q[i] <= pe_q[i-1];
      end
    end
  end

  assign mem_bus.rsp_err = pe_q[LAST];
`endif

endmodule

`default_nettype wire

// File: tb/tb_ramb_multirank.sv
// ============================================================================
// tb_ramb_multirank : directed self-checking bench for ramb_multirank.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ramb_multirank;
  localparam int DW = 16;
  localparam int RL = 3;
  localparam int TA = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ramb_multirank_if #(.NUM_RANKS(2), .WORDADDR_WIDTH(7), .DATA_WIDTH(DW)) bus_a ();
  ramb_multirank_if #(.NUM_RANKS(2), .WORDADDR_WIDTH(7), .DATA_WIDTH(8))  bus_b ();

  ramb_multirank #(.NUM_RANKS(2), .WORDADDR_WIDTH(7), .DATA_WIDTH(DW),
                   .READ_LATENCY(RL), .TURNAROUND(TA))
    u_dut_a (.clk(clk), .rst(rst), .mem_bus(bus_a));

  ramb_multirank u_dut_b (.clk(clk), .rst(rst), .mem_bus(bus_b));

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [15];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request on bus_a from the +1 phase; returns +1 after the accept edge.
  task automatic issue_a(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                         input logic [1:0] be);
    int n;
    bus_a.req_valid = 1'b1;
    bus_a.req_wr    = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wd;
    bus_a.req_be    = be;
    #1;
    n = 0;
    while (!bus_a.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: addr 0x%0h never accepted", addr);
    end
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    bus_a.req_be    = '0;
  endtask

  task automatic expect_rsp_a(input string name, input logic [15:0] exp_d, input logic exp_rank);
    int n;
    n = 0;
    while (!bus_a.rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, RL - 1);
    check({name, "_data"}, bus_a.rsp_rdata, exp_d);
    check({name, "_rank"}, bus_a.rsp_rank, exp_rank);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bb_addr [4];
    logic [15:0] bb_exp  [4];
    logic        seen;

    bus_a.req_valid = 1'b0; bus_a.req_wr = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.req_be = '0;
    bus_b.req_valid = 1'b0; bus_b.req_wr = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.req_be = '0;
`ifdef RAMB_PARITY_EN
    bus_a.inj_err = 1'b0;
    bus_b.inj_err = 1'b0;
`endif

    vecs[0]  = '{1'b1, 8'h05, 16'h1234, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 8'h05, 16'hABCD, 2'b01, 16'h0000};
    vecs[2]  = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'h12CD};
    vecs[3]  = '{1'b1, 8'h85, 16'h5555, 2'b11, 16'h0000};
    vecs[4]  = '{1'b1, 8'hFF, 16'h0000, 2'b11, 16'h0000};
    vecs[5]  = '{1'b1, 8'hFF, 16'hFFFF, 2'b10, 16'h0000};
    vecs[6]  = '{1'b0, 8'h85, 16'h0000, 2'b00, 16'h5555};
    vecs[7]  = '{1'b1, 8'h00, 16'h0102, 2'b11, 16'h0000};
    vecs[8]  = '{1'b1, 8'h00, 16'hBEEF, 2'b00, 16'h0000};
    vecs[9]  = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h0102};
    vecs[10] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'hFF00};
    vecs[11] = '{1'b1, 8'h06, 16'h00FF, 2'b11, 16'h0000};
    vecs[12] = '{1'b0, 8'h06, 16'h0000, 2'b00, 16'h00FF};
    vecs[13] = '{1'b1, 8'h10, 16'hC3C3, 2'b11, 16'h0000};
    vecs[14] = '{1'b0, 8'h05, 16'h0000, 2'b00, 16'h12CD};

    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus_a.rsp_valid, 0);
    check("rst_busy",      bus_a.busy,      0);
    check("rst_rdata",     bus_a.rsp_rdata, 0);
    check("rst_rank",      bus_a.rsp_rank,  0);
    check("rst_ready",     bus_a.req_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Default instance: 8-bit, latency 1, turnaround 1.
    bus_b.req_valid = 1'b1; bus_b.req_wr = 1'b1; bus_b.req_addr = 8'h05;
    bus_b.req_wdata = 8'hA5; bus_b.req_be = 1'b1;
    #1;
    check("b_first_ready", bus_b.req_ready, 1);
    @(posedge clk); #1;
    bus_b.req_wr = 1'b0;
    @(posedge clk); #1;
    bus_b.req_addr = 8'h85;
    check("b_rsp_valid", bus_b.rsp_valid, 1);
    check("b_rsp_data",  bus_b.rsp_rdata, 8'hA5);
    check("b_rsp_rank",  bus_b.rsp_rank,  0);
    #1;
    check("b_ta_stall", bus_b.req_ready, 0);
    @(posedge clk); #1;
    check("b_rsp_pulse_end", bus_b.rsp_valid, 0);
    check("b_rsp_hold",      bus_b.rsp_rdata, 8'hA5);
    check("b_ta_ready",      bus_b.req_ready, 1);
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    check("b_r1_valid", bus_b.rsp_valid, 1);
    check("b_r1_rank",  bus_b.rsp_rank,  1);

    for (int i = 0; i < 15; i++) begin
      issue_a(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      if (!vecs[i].wr) expect_rsp_a($sformatf("vec%0d", i), vecs[i].exp, vecs[i].addr[7]);
    end

    // Turnaround 2: rank 1 waits two full cycles after a rank 0 accept.
    bus_a.req_valid = 1'b1; bus_a.req_wr = 1'b0; bus_a.req_addr = 8'h05;
    #1;
    check("ta_r0_ready", bus_a.req_ready, 1);
    @(posedge clk); #1;
    bus_a.req_addr = 8'h85;
    #1;
    check("ta_stall1", bus_a.req_ready, 0);
    @(posedge clk); #1;
    check("ta_stall2", bus_a.req_ready, 0);
    @(posedge clk); #1;
    check("ta_ready",      bus_a.req_ready, 1);
    check("ta_r0_rsp",     bus_a.rsp_valid, 1);
    check("ta_r0_rsp_dat", bus_a.rsp_rdata, 16'h12CD);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    expect_rsp_a("ta_r1", 16'h5555, 1'b1);

    bus_a.req_valid = 1'b1; bus_a.req_addr = 8'hFF;
    #1;
    @(posedge clk); #1;
    bus_a.req_addr = 8'h85;
    #1;
    check("same_rank_ready", bus_a.req_ready, 1);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    @(posedge clk); #1;
    check("sr_rsp0_data", bus_a.rsp_rdata, 16'hFF00);
    @(posedge clk); #1;
    check("sr_rsp1_valid", bus_a.rsp_valid, 1);
    check("sr_rsp1_data",  bus_a.rsp_rdata, 16'h5555);
    @(posedge clk); #1;

    // Four back-to-back reads through the 3-deep pipeline.
    bb_addr[0] = 8'h05; bb_exp[0] = 16'h12CD;
    bb_addr[1] = 8'h06; bb_exp[1] = 16'h00FF;
    bb_addr[2] = 8'h00; bb_exp[2] = 16'h0102;
    bb_addr[3] = 8'h10; bb_exp[3] = 16'hC3C3;
    bus_a.req_valid = 1'b1; bus_a.req_wr = 1'b0; bus_a.req_addr = bb_addr[0];
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k + 1 < 4) bus_a.req_addr = bb_addr[k+1];
      else           bus_a.req_valid = 1'b0;
      check($sformatf("bb_valid%0d", k), bus_a.rsp_valid, (k >= 2 && k <= 5) ? 1 : 0);
      if (k >= 2 && k <= 5) check($sformatf("bb_data%0d", k), bus_a.rsp_rdata, bb_exp[k-2]);
      check($sformatf("bb_busy%0d", k), bus_a.busy, (k <= 5) ? 1 : 0);
    end

    // Reset with two reads in flight.
    bus_a.req_valid = 1'b1; bus_a.req_addr = 8'h05;
    @(posedge clk); #1;
    bus_a.req_addr = 8'h06;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    check("mid_busy_pre", bus_a.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus_a.rsp_valid, 0);
    check("mid_rst_busy",  bus_a.busy,      0);
    check("mid_rst_rdata", bus_a.rsp_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bus_a.rsp_valid) seen = 1'b1;
    end
    check("mid_no_stale_rsp", seen, 0);
    bus_a.req_valid = 1'b1; bus_a.req_addr = 8'h85;
    #1;
    check("post_rst_r1_ready", bus_a.req_ready, 1);
    bus_a.req_valid = 1'b0;
    issue_a(1'b0, 8'h85, 16'h0000, 2'b00);
    expect_rsp_a("post_rst_r1", 16'h5555, 1'b1);
    issue_a(1'b0, 8'h05, 16'h0000, 2'b00);
    expect_rsp_a("post_rst_r0", 16'h12CD, 1'b0);

`ifdef RAMB_PARITY_EN
    issue_a(1'b1, 8'h20, 16'h000F, 2'b11);
    bus_a.inj_err = 1'b1;
    issue_a(1'b1, 8'h20, 16'h000F, 2'b01);
    bus_a.inj_err = 1'b0;
    issue_a(1'b0, 8'h20, 16'h0000, 2'b00);
    expect_rsp_a("par_inj", 16'h000F, 1'b0);
    check("par_err_inj", bus_a.rsp_err, 2'b01);
    issue_a(1'b1, 8'h20, 16'h000F, 2'b01);
    issue_a(1'b0, 8'h20, 16'h0000, 2'b00);
    expect_rsp_a("par_clean", 16'h000F, 1'b0);
    check("par_err_clean", bus_a.rsp_err, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
